// File: rtl/riscv_core_hazard_ctrl.sv
// Hazard controller for the five-stage RV64 core: EX operand forwarding, load-use bubbles,
// branch flushes and (with RISCV_HAZARD_MDU_EN defined) multicycle MUL/DIV stalls.
module riscv_core_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [REG_ADDR_W-1:0]  i_id_rs1_addr,
    input  logic [REG_ADDR_W-1:0]  i_id_rs2_addr,
    input  logic [REG_ADDR_W-1:0]  i_ex_rs1_addr,
    input  logic [REG_ADDR_W-1:0]  i_ex_rs2_addr,
    input  logic [REG_ADDR_W-1:0]  i_ex_rd_addr,
    input  logic                   i_ex_is_load,
    input  logic                   i_ex_mdu_start,
    input  logic                   i_mdu_done,
    input  logic                   i_ex_branch_taken,
    input  logic [REG_ADDR_W-1:0]  i_mem_rd_addr,
    input  logic                   i_mem_reg_write,
    input  logic [REG_ADDR_W-1:0]  i_wb_rd_addr,
    input  logic                   i_wb_reg_write,
    output logic [1:0]             o_fwd_a_sel,
    output logic [1:0]             o_fwd_b_sel,
    output logic                   o_stall_if,
    output logic                   o_stall_id,
    output logic                   o_stall_ex,
    output logic                   o_flush_id,
    output logic                   o_flush_ex,
    output logic                   o_mdu_busy,
    output logic [STALL_CNT_W-1:0] o_stall_cycles
);

    // state    | meaning
    // RUN      | normal issue, hazards detected here
    // LD_STALL | single bubble cycle after a load-use, load now forwarded from MEM
    // MDU_WAIT | holding IF/ID/EX until the MDU result is valid
`ifdef RISCV_HAZARD_MDU_EN
    typedef enum logic [1:0] {RUN = 2'd0, LD_STALL = 2'd1, MDU_WAIT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {RUN = 2'd0, LD_STALL = 2'd1} state_t;
`endif

    state_t state, state_nxt;
    logic   mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic   load_use;
    logic   stall_fe, stall_ex, flush_id, flush_ex;

    assign mem_hit_a = i_mem_reg_write && (i_mem_rd_addr != '0) && (i_mem_rd_addr == i_ex_rs1_addr);
    assign mem_hit_b = i_mem_reg_write && (i_mem_rd_addr != '0) && (i_mem_rd_addr == i_ex_rs2_addr);
    assign wb_hit_a  = i_wb_reg_write && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_ex_rs1_addr);
    assign wb_hit_b  = i_wb_reg_write && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_ex_rs2_addr);

    assign o_fwd_a_sel = mem_hit_a ? 2'b10 : (wb_hit_a ? 2'b01 : 2'b00);
    assign o_fwd_b_sel = mem_hit_b ? 2'b10 : (wb_hit_b ? 2'b01 : 2'b00);

    assign load_use = i_ex_is_load && (i_ex_rd_addr != '0) &&
                      ((i_ex_rd_addr == i_id_rs1_addr) || (i_ex_rd_addr == i_id_rs2_addr));

    always_comb begin
        stall_fe  = 1'b0;
        stall_ex  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        state_nxt = state;
        case (state)
            RUN: begin
                if (i_ex_branch_taken) begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (load_use) begin
                    stall_fe  = 1'b1;
                    flush_ex  = 1'b1;
                    state_nxt = LD_STALL;
                end
`ifdef RISCV_HAZARD_MDU_EN
                // A done pulse coincident with start means a zero-wait op: no stall.
                else if (i_ex_mdu_start && !i_mdu_done) begin
                    stall_fe  = 1'b1;
                    stall_ex  = 1'b1;
                    state_nxt = MDU_WAIT;
                end
`endif
            end
            LD_STALL: state_nxt = RUN;
`ifdef RISCV_HAZARD_MDU_EN
            MDU_WAIT: begin
                if (i_mdu_done) begin
                    state_nxt = RUN;
                end else begin
                    stall_fe = 1'b1;
                    stall_ex = 1'b1;
                end
            end
`endif
            default: state_nxt = RUN;
        endcase
        if (!i_rst_n) begin
            stall_fe = 1'b0;
            stall_ex = 1'b0;
            flush_id = 1'b0;
            flush_ex = 1'b0;
        end
    end

    assign o_stall_if = stall_fe;
    assign o_stall_id = stall_fe;
    assign o_flush_id = flush_id;
    assign o_flush_ex = flush_ex;

`ifdef RISCV_HAZARD_MDU_EN
    assign o_stall_ex = stall_ex;
    assign o_mdu_busy = (state == MDU_WAIT) && i_rst_n;
`else
    logic unused_mdu;
    assign unused_mdu = i_ex_mdu_start ^ i_mdu_done ^ stall_ex;
    assign o_stall_ex = 1'b0;
    assign o_mdu_busy = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= RUN;
            o_stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            if (stall_fe && (o_stall_cycles != '1))
                o_stall_cycles <= o_stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_core_hazard_ctrl.sv
// Self-checking bench for riscv_core_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, both compared against a rule-level reference model.
module tb_riscv_core_hazard_ctrl;

    localparam int AW   = 5;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;
`ifdef RISCV_HAZARD_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          ex_load, mdu_start, mdu_done, br_taken, mem_w, wb_w;
    logic [1:0]    fwd_a, fwd_b;
    logic          stall_if, stall_id, stall_ex, flush_id, flush_ex, mdu_busy;
    logic [CW-1:0] stall_cycles;

    int compared   = 0;
    int mismatched = 0;

    // reference model: which special cycle we are in, and the stall-cycle tally
    bit m_ld, m_mdu;
    int m_cnt;
    bit n_ld, n_mdu;
    bit e_sf, e_se, e_fi, e_fe, e_busy;

    always #5 clk = ~clk;

    riscv_core_hazard_ctrl #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_rs1_addr(id_rs1), .i_id_rs2_addr(id_rs2),
        .i_ex_rs1_addr(ex_rs1), .i_ex_rs2_addr(ex_rs2), .i_ex_rd_addr(ex_rd),
        .i_ex_is_load(ex_load), .i_ex_mdu_start(mdu_start), .i_mdu_done(mdu_done),
        .i_ex_branch_taken(br_taken),
        .i_mem_rd_addr(mem_rd), .i_mem_reg_write(mem_w),
        .i_wb_rd_addr(wb_rd), .i_wb_reg_write(wb_w),
        .o_fwd_a_sel(fwd_a), .o_fwd_b_sel(fwd_b),
        .o_stall_if(stall_if), .o_stall_id(stall_id), .o_stall_ex(stall_ex),
        .o_flush_id(flush_id), .o_flush_ex(flush_ex),
        .o_mdu_busy(mdu_busy), .o_stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_fwd(input logic [AW-1:0] rs);
        if (mem_w && mem_rd != 0 && mem_rd == rs) return 2;
        if (wb_w && wb_rd != 0 && wb_rd == rs) return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_load = 0; mdu_start = 0; mdu_done = 0; br_taken = 0; mem_w = 0; wb_w = 0;
    endtask

    task automatic model_reset();
        m_ld = 0; m_mdu = 0; m_cnt = 0;
    endtask

    // settle mid-cycle, compare every output with the model, and work out the model's next state
    task automatic settle();
        bit lu;
        #3;
        lu = ex_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        e_sf = 0; e_se = 0; e_fi = 0; e_fe = 0; e_busy = 0;
        n_ld = 0; n_mdu = 0;
        if (rst_n) begin
            if (m_mdu) begin
                e_busy = 1;
                e_sf = !mdu_done;
                e_se = !mdu_done;
                n_mdu = !mdu_done;
            end else if (m_ld) begin
                // bubble cycle: nothing asserted, nothing detected
            end else if (br_taken) begin
                e_fi = 1; e_fe = 1;
            end else if (lu) begin
                e_sf = 1; e_fe = 1; n_ld = 1;
            end else if (MDU_EN && mdu_start && !mdu_done) begin
                e_sf = 1; e_se = 1; n_mdu = 1;
            end
        end
        chk("fwd_a", fwd_a, ref_fwd(ex_rs1));
        chk("fwd_b", fwd_b, ref_fwd(ex_rs2));
        chk("stall_if", stall_if, e_sf);
        chk("stall_id", stall_id, e_sf);
        chk("stall_ex", stall_ex, e_se);
        chk("flush_id", flush_id, e_fi);
        chk("flush_ex", flush_ex, e_fe);
        chk("mdu_busy", mdu_busy, e_busy);
        chk("stall_cycles", stall_cycles, m_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_ld = n_ld;
            m_mdu = n_mdu;
            if (e_sf && m_cnt < CMAX) m_cnt++;
        end else begin
            model_reset();
        end
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        step();
        rst_n = 1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        model_reset();
        settle();
        chk("reset_cnt", stall_cycles, 0);
        advance();
        rst_n = 1;

        // forwarding priority and x0 suppression
        mem_rd = 5; mem_w = 1; wb_rd = 5; wb_w = 1; ex_rs1 = 5; ex_rs2 = 0;
        settle();
        chk("fwd_a_mem_prio", fwd_a, 2);
        chk("fwd_b_x0src", fwd_b, 0);
        advance();
        mem_rd = 0; wb_rd = 0; ex_rs1 = 0;
        settle();
        chk("fwd_a_x0", fwd_a, 0);
        advance();
        mem_w = 0; wb_rd = 9; ex_rs2 = 9;
        settle();
        chk("fwd_b_wb", fwd_b, 1);
        advance();

        // load-use: one stall, one masked bubble cycle, then back in RUN
        do_reset();
        ex_load = 1; ex_rd = 7; id_rs2 = 7;
        settle();
        chk("lu_stall", stall_if, 1);
        chk("lu_flush", flush_ex, 1);
        advance();
        settle();
        chk("lu_masked", stall_if, 0);
        advance();
        clear_inputs();
        settle();
        chk("lu_cnt", stall_cycles, 1);
        advance();

        // branch beats load-use; state stays RUN so the next LU is seen at once
        do_reset();
        ex_load = 1; ex_rd = 7; id_rs2 = 7; br_taken = 1;
        settle();
        chk("br_flush_id", flush_id, 1);
        chk("br_nostall", stall_if, 0);
        advance();
        br_taken = 0;
        settle();
        chk("br_then_lu", stall_if, 1);
        advance();
        clear_inputs();
        step();

        // MDU op with done four cycles after start
        do_reset();
        mdu_start = 1;
        settle();
        chk("mdu_start_stall", stall_ex, MDU_EN);
        advance();
        mdu_start = 0;
        repeat (3) step();
        mdu_done = 1;
        settle();
        chk("mdu_done_release", stall_if, 0);
        advance();
        mdu_done = 0;
        settle();
        chk("mdu_cnt", stall_cycles, MDU_EN ? 4 : 0);
        advance();

        // zero-wait MDU op
        mdu_start = 1; mdu_done = 1;
        settle();
        chk("mdu_zero_wait", stall_if, 0);
        advance();
        clear_inputs();
        step();

        // reset during the second MDU_WAIT cycle
        do_reset();
        mdu_start = 1;
        step();
        mdu_start = 0;
        step();
        rst_n = 0;
        model_reset();
        settle();
        chk("rst_mid_stall", stall_if, 0);
        chk("rst_mid_busy", mdu_busy, 0);
        chk("rst_mid_cnt", stall_cycles, 0);
        advance();
        rst_n = 1;
        ex_load = 1; ex_rd = 3; id_rs1 = 3;
        settle();
        chk("rst_then_run", stall_if, 1);
        advance();
        clear_inputs();
        step();

        // counter saturation via back-to-back load-use pairs
        do_reset();
        ex_load = 1; ex_rd = 4; id_rs1 = 4;
        repeat (80) step();
        clear_inputs();
        settle();
        chk("sat_lu", stall_cycles, CMAX);
        advance();

        // counter saturation via one long MDU stall
        do_reset();
        mdu_start = 1;
        step();
        mdu_start = 0;
        repeat (40) step();
        settle();
        chk("sat_mdu", stall_cycles, MDU_EN ? CMAX : 0);
        advance();
        mdu_done = 1;
        step();
        clear_inputs();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            id_rs1    = AW'($urandom_range(0, 3));
            id_rs2    = AW'($urandom_range(0, 3));
            ex_rs1    = AW'($urandom_range(0, 3));
            ex_rs2    = AW'($urandom_range(0, 3));
            ex_rd     = AW'($urandom_range(0, 3));
            mem_rd    = AW'($urandom_range(0, 3));
            wb_rd     = AW'($urandom_range(0, 3));
            mem_w     = 1'($urandom_range(0, 1));
            wb_w      = 1'($urandom_range(0, 1));
            ex_load   = ($urandom_range(0, 2) == 0);
            br_taken  = ($urandom_range(0, 5) == 0);
            mdu_start = ($urandom_range(0, 3) == 0);
            mdu_done  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 0;
                model_reset();
            end else begin
                rst_n = 1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
